parity_frame_tx: RTL

Serial frame transmitter placed directly downstream of the byte parity generator. It accepts a data byte plus its computed even-parity bit over a valid/ready handshake. It then shifts out a UART-style frame on a single line: start bit, data bits LSB first, parity bit, stop bit. Bit timing comes from an internal clock-cycles-per-bit counter.

---
 rtl/parity_frame_tx_if.sv | 13 +
 rtl/parity_frame_tx.sv | 104 ++++++++++
 2 files changed

// File: rtl/parity_frame_tx_if.sv
// Byte handshake between the upstream parity stage and the frame transmitter.
// The upstream stage drives data and parity; the transmitter answers with data_ready.
interface parity_frame_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  parity_in;
    logic                  data_valid;
    logic                  data_ready;

    modport master (output data_in, output parity_in, output data_valid, input data_ready);
    modport slave  (input data_in, input parity_in, input data_valid, output data_ready);
endinterface

// File: rtl/parity_frame_tx.sv
// UART-style frame transmitter: start, DATA_WIDTH data bits LSB first, parity, stop.
// Each bit is held for CLKS_PER_BIT clocks.
module parity_frame_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    parity_frame_tx_if.slave    bus,
    output logic                tx_out,
    output logic                busy,
    output logic                frame_done
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
    localparam logic ODD_BIT = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_nxt;
    logic [TW-1:0]         timer, timer_nxt;
    logic [BW-1:0]         bit_idx, bit_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic                  par, par_nxt;
    logic                  tx_nxt, done_nxt, last;

    assign bus.data_ready = (state == IDLE);
    assign last = (timer == T_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            bit_idx    <= bit_nxt;
            shreg      <= shreg_nxt;
            par        <= par_nxt;
            tx_out     <= tx_nxt;
            busy       <= (state_nxt != IDLE);
            frame_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        par_nxt   = par;

        if (state != IDLE)
            timer_nxt = last ? '0 : timer + TW'(1);

        case (state)
            IDLE: begin
                if (bus.data_valid) begin
                    state_nxt = START;
                    shreg_nxt = bus.data_in;
                    par_nxt   = bus.parity_in ^ ODD_BIT;
                    timer_nxt = '0;
                    bit_nxt   = '0;
                end
            end
            START:  if (last) state_nxt = DATA;
            DATA: begin
                if (last) begin
                    shreg_nxt = shreg >> 1;
                    if (bit_idx == B_LAST) begin
                        state_nxt = PARITY;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_idx + BW'(1);
                    end
                end
            end
            PARITY: if (last) state_nxt = STOP;
            STOP:   if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the values the state takes next.
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
            PARITY:  tx_nxt = par_nxt;
            default: tx_nxt = 1'b1;
        endcase
        done_nxt = (state_nxt == STOP) && (timer_nxt == T_LAST);
    end
endmodule
